// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the load-use hazard controller.
package hazard_pkg;
    localparam int REG_ADDR_W_DEF = 5;
    localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic valid;
        logic [REG_ADDR_W_DEF-1:0] rd;
    } sb_entry_t;
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: shift register of in-flight load destinations; slot 0 is EX.
// hit reports any valid slot whose rd matches a used ID source.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift,
    input  logic                  push_valid,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic                  use_rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs2,
    output logic                  hit
);
    logic [LOAD_LAT-1:0]                 valid_q, valid_d;
    logic [LOAD_LAT-1:0][REG_ADDR_W-1:0] rd_q, rd_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        hit     = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++)
            hit |= valid_q[i] & ((use_rs1 && rs1 == rd_q[i]) || (use_rs2 && rs2 == rd_q[i]));
        if (shift) begin
            // x0 never enters, so it can never stall a reader
            valid_d[0] = push_valid && push_rd != REG_ADDR_W'(REG_ZERO);
            rd_d[0]    = push_rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use stall, memory freeze and redirect flush control
// for PC, IF/ID and ID/EX, plus a saturating hazard-stall counter.
module load_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs1,
    input  logic [REG_ADDR_W-1:0] ID_Rs2,
    input  logic                  ID_UsesRs1,
    input  logic                  ID_UsesRs2,
    input  logic                  ID_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_Rd,
    input  logic                  Mem_Stall,
    input  logic                  Redirect,
    output logic                  PC_WriteEn,
    output logic                  IFID_WriteEn,
    output logic                  IFID_Flush,
    output logic                  IDEX_Flush,
    output logic [CNT_W-1:0]      Stall_Cycles
);
    logic             hit, hz;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    assign hz = ID_Valid & hit;

    // A killed or stalled ID instruction must not enter; a bubble shifts in instead
    load_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .LOAD_LAT(LOAD_LAT)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .shift     (!Mem_Stall),
        .push_valid(ID_Valid & ID_MemRead & !Redirect & !hz),
        .push_rd   (ID_Rd),
        .rs1       (ID_Rs1),
        .use_rs1   (ID_UsesRs1),
        .rs2       (ID_Rs2),
        .use_rs2   (ID_UsesRs2),
        .hit       (hit)
    );

    always_comb begin
        PC_WriteEn     = 1'b1;
        IFID_WriteEn   = 1'b1;
        IFID_Flush     = 1'b0;
        IDEX_Flush     = 1'b0;
        stall_cycles_d = stall_cycles_q;
        if (Mem_Stall) begin
            PC_WriteEn   = 1'b0;
            IFID_WriteEn = 1'b0;
        end else if (Redirect) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (hz) begin
            PC_WriteEn     = 1'b0;
            IFID_WriteEn   = 1'b0;
            IDEX_Flush     = 1'b1;
            stall_cycles_d = &stall_cycles_q ? stall_cycles_q : stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign Stall_Cycles = stall_cycles_q;
endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb_load_hazard_ctrl: three controllers (LOAD_LAT 1/3/8, the last with a 4-bit
// counter) share stimulus and are checked against a list-of-pending-loads model.
module tb_load_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, use1 = 1'b0, use2 = 1'b0, memread = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       mem = 1'b0, redir = 1'b0;
    logic [2:0] pc_w, we_w, iff_w, idf_w;
    logic [15:0] c0, c1;
    logic [3:0]  c2;

    int total = 0, passed = 0;
    int mrd[3][16];
    int mleft[3][16];
    int mn[3];
    int mcnt[3];

    always #5 clk = ~clk;

    load_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) d0 (
        .clk(clk), .reset(reset), .ID_Valid(id_valid), .ID_Rs1(rs1), .ID_Rs2(rs2),
        .ID_UsesRs1(use1), .ID_UsesRs2(use2), .ID_MemRead(memread), .ID_Rd(rd),
        .Mem_Stall(mem), .Redirect(redir), .PC_WriteEn(pc_w[0]), .IFID_WriteEn(we_w[0]),
        .IFID_Flush(iff_w[0]), .IDEX_Flush(idf_w[0]), .Stall_Cycles(c0));
    load_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) d1 (
        .clk(clk), .reset(reset), .ID_Valid(id_valid), .ID_Rs1(rs1), .ID_Rs2(rs2),
        .ID_UsesRs1(use1), .ID_UsesRs2(use2), .ID_MemRead(memread), .ID_Rd(rd),
        .Mem_Stall(mem), .Redirect(redir), .PC_WriteEn(pc_w[1]), .IFID_WriteEn(we_w[1]),
        .IFID_Flush(iff_w[1]), .IDEX_Flush(idf_w[1]), .Stall_Cycles(c1));
    load_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(8), .CNT_W(4)) d2 (
        .clk(clk), .reset(reset), .ID_Valid(id_valid), .ID_Rs1(rs1), .ID_Rs2(rs2),
        .ID_UsesRs1(use1), .ID_UsesRs2(use2), .ID_MemRead(memread), .ID_Rd(rd),
        .Mem_Stall(mem), .Redirect(redir), .PC_WriteEn(pc_w[2]), .IFID_WriteEn(we_w[2]),
        .IFID_Flush(iff_w[2]), .IDEX_Flush(idf_w[2]), .Stall_Cycles(c2));

    function automatic int lat(int k);
        return k == 0 ? 1 : k == 1 ? 3 : 8;
    endfunction

    function automatic int cmax(int k);
        return k == 2 ? 15 : 65535;
    endfunction

    function automatic logic [31:0] dut_cnt(int k);
        return k == 0 ? 32'(c0) : k == 1 ? 32'(c1) : 32'(c2);
    endfunction

    function automatic bit m_hz(int k);
        bit h = 1'b0;
        if (id_valid)
            for (int j = 0; j < mn[k]; j++)
                if ((use1 && int'(rs1) == mrd[k][j]) || (use2 && int'(rs2) == mrd[k][j])) h = 1'b1;
        return h;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic set_in(bit v, bit mr, int d, int s1, bit u1, int s2, bit u2);
        id_valid = v; memread = mr; rd = 5'(d);
        rs1 = 5'(s1); use1 = u1; rs2 = 5'(s2); use2 = u2;
    endtask

    task automatic check_outputs(string tag);
        bit h;
        bit e_pc, e_we, e_iff, e_idf;
        for (int k = 0; k < 3; k++) begin
            h = m_hz(k);
            e_pc  = !mem && (redir || !h);
            e_we  = e_pc;
            e_iff = !mem && redir;
            e_idf = !mem && (redir || h);
            chk($sformatf("%s_pc%0d", tag, k), 32'(pc_w[k]), 32'(e_pc));
            chk($sformatf("%s_we%0d", tag, k), 32'(we_w[k]), 32'(e_we));
            chk($sformatf("%s_iff%0d", tag, k), 32'(iff_w[k]), 32'(e_iff));
            chk($sformatf("%s_idf%0d", tag, k), 32'(idf_w[k]), 32'(e_idf));
            chk($sformatf("%s_cnt%0d", tag, k), dut_cnt(k), 32'(mcnt[k]));
        end
    endtask

    task automatic m_advance();
        bit h;
        int n;
        for (int k = 0; k < 3; k++) begin
            if (mem) continue;
            h = m_hz(k);
            n = 0;
            for (int j = 0; j < mn[k]; j++)
                if (mleft[k][j] > 1) begin
                    mrd[k][n] = mrd[k][j];
                    mleft[k][n] = mleft[k][j] - 1;
                    n++;
                end
            mn[k] = n;
            if (redir) ;
            else if (h) mcnt[k] = mcnt[k] < cmax(k) ? mcnt[k] + 1 : mcnt[k];
            else if (id_valid && memread && rd != 0) begin
                mrd[k][n] = int'(rd);
                mleft[k][n] = lat(k);
                mn[k] = n + 1;
            end
        end
    endtask

    task automatic cyc(string tag);
        @(negedge clk);
        check_outputs(tag);
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0;
            mcnt[k] = 0;
        end
        check_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit prev_hold;
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0;
            mcnt[k] = 0;
        end
        #1;
        check_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("idle");

        set_in(1, 1, 5, 0, 0, 0, 0); cyc("t1_ld");
        set_in(1, 0, 6, 5, 1, 0, 0); cyc("t1_use");
        chk("t1_cnt_lat1", 32'(c0), 32'd1);
        set_in(1, 0, 6, 5, 1, 0, 0); cyc("t1_issue");
        chk("t1_issue_pc", 32'(pc_w[0]), 32'd1);

        do_reset("t2_rst");
        set_in(1, 1, 7, 0, 0, 0, 0); cyc("t2_ld");
        set_in(1, 0, 8, 1, 1, 2, 1); cyc("t2_ind");
        repeat (4) begin set_in(1, 0, 9, 3, 1, 7, 1); cyc("t2_use"); end
        chk("t2_cnt_lat3", 32'(c1), 32'd2);

        do_reset("t3_rst");
        set_in(1, 1, 0, 0, 0, 0, 0); cyc("t3_ld0");
        set_in(1, 0, 4, 0, 1, 0, 1); cyc("t3_use0");
        set_in(1, 1, 9, 0, 0, 0, 0); cyc("t3_ld9");
        set_in(1, 0, 4, 9, 0, 1, 1); cyc("t3_nouse");
        set_in(0, 0, 0, 9, 1, 9, 1); cyc("t3_invalid");
        chk("t3_cnt0", 32'(c0), 32'd0);
        chk("t3_cnt2", 32'(c2), 32'd0);

        do_reset("t4_rst");
        set_in(1, 1, 3, 0, 0, 0, 0); cyc("t4_ld");
        set_in(1, 0, 4, 3, 1, 0, 0); cyc("t4_stall");
        mem = 1'b1;
        repeat (4) cyc("t4_freeze");
        mem = 1'b0;
        repeat (9) cyc("t4_resume");
        chk("t4_cnt_lat1", 32'(c0), 32'd1);
        chk("t4_cnt_lat3", 32'(c1), 32'd3);
        chk("t4_cnt_lat8", 32'(c2), 32'd8);

        do_reset("t5_rst");
        set_in(1, 1, 4, 0, 0, 0, 0); cyc("t5_ld");
        set_in(1, 0, 5, 4, 1, 0, 0); redir = 1'b1; cyc("t5_redir_hz");
        redir = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0); cyc("t5_idle");
        redir = 1'b1; mem = 1'b1;
        repeat (2) cyc("t5_redir_frozen");
        mem = 1'b0; cyc("t5_redir_go");
        redir = 1'b0; cyc("t5_after");
        chk("t5_cnt", 32'(c1), 32'd0);

        do_reset("t6_rst");
        repeat (4) begin
            set_in(1, 1, 2, 0, 0, 0, 0); cyc("t6_ld");
            repeat (9) begin set_in(1, 0, 6, 2, 1, 0, 0); cyc("t6_use"); end
        end
        chk("t6_sat", 32'(c2), 32'd15);
        set_in(1, 1, 2, 0, 0, 0, 0); cyc("t6_ld2");
        set_in(1, 0, 6, 0, 0, 2, 1); cyc("t6_midstall");
        do_reset("t6_async");
        chk("t6_rst_cnt", 32'(c2), 32'd0);

        prev_hold = 1'b0;
        repeat (400) begin
            set_in($urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
            mem = $urandom_range(0, 5) == 0;
            redir = prev_hold ? 1'b1 : $urandom_range(0, 7) == 0;
            prev_hold = redir && mem;
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            else cyc("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
